// File: rtl/hyperbus_trans_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_trans_arbiter
// Purpose  : Shares one hyperbus transaction port (trans / tx / rx / b
//            channels) between NR_REQ requesters. Round-robin grant, held
//            from trans issue until the read (rx last) or write (b last)
//            completes. The data channels follow the grant combinationally.
// Ports    : clk_i, rst_i (sync, active-high)
//            s_trans_*  per-requester transaction request / accept
//            s_tx_*     per-requester write data (routed to m_tx_*)
//            s_rx_*     per-requester read data (from m_rx_*)
//            s_b_*      per-requester write response (from m_b_*)
//            m_*        single master transaction port
//            timeout_o  sticky watchdog flag
// Options  : HYPERBUS_ARB_WDOG_EN - enables the data-beat watchdog. Without
//            it timeout_o is tied low and a burst ends only on its last beat.
// Revision : 1.0 - initial release
// ============================================================================
module hyperbus_trans_arbiter #(
    parameter int NR_REQ      = 2,
    parameter int NR_CS       = 2,
    parameter int BURST_WIDTH = 12,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NR_REQ-1:0]                             s_trans_valid_i,
    output logic [NR_REQ-1:0]                             s_trans_ready_o,
    input  logic [NR_REQ*(NR_CS+BURST_WIDTH+35)-1:0]      s_trans_i,
    input  logic [NR_REQ-1:0]                             s_tx_valid_i,
    output logic [NR_REQ-1:0]                             s_tx_ready_o,
    input  logic [NR_REQ*16-1:0]                          s_tx_data_i,
    input  logic [NR_REQ*2-1:0]                           s_tx_strb_i,
    output logic [NR_REQ-1:0]                             s_rx_valid_o,
    input  logic [NR_REQ-1:0]                             s_rx_ready_i,
    output logic [17:0]                                   s_rx_o,
    output logic [NR_REQ-1:0]                             s_b_valid_o,
    input  logic [NR_REQ-1:0]                             s_b_ready_i,
    output logic [1:0]                                    s_b_o,
    output logic                                          m_trans_valid_o,
    input  logic                                          m_trans_ready_i,
    output logic [NR_CS+BURST_WIDTH+35-1:0]               m_trans_o,
    output logic                                          m_tx_valid_o,
    input  logic                                          m_tx_ready_i,
    output logic [15:0]                                   m_tx_data_o,
    output logic [1:0]                                    m_tx_strb_o,
    input  logic                                          m_rx_valid_i,
    output logic                                          m_rx_ready_o,
    input  logic [17:0]                                   m_rx_i,
    input  logic                                          m_b_valid_i,
    output logic                                          m_b_ready_o,
    input  logic [1:0]                                    m_b_i,
    output logic                                          timeout_o
);

    localparam int GW     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int TW     = NR_CS + BURST_WIDTH + 35;
    // trans layout {cs, write, burst, burst_type, address_space, address[31:0]}
    localparam int WR_BIT = BURST_WIDTH + 34;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;  // watchdog error beat to grantee

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [GW-1:0] r_gnt;
    logic [GW-1:0] r_rr;
    logic [TW-1:0] r_trans;

    logic          w_any;
    logic [GW-1:0] w_sel;
    logic          w_rx_hs;
    logic          w_tx_hs;
    logic          w_b_hs;
    logic          w_err_hs;
    logic          w_wd_fire;
    logic          w_is_wr;

    assign w_any   = |s_trans_valid_i;
    assign w_is_wr = r_trans[WR_BIT];

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin : p_select
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        w_sel = r_rr;
        for (int k = 0; k < NR_REQ; k++) begin
            idx = (int'(r_rr) + k) % NR_REQ;
            if (!found && s_trans_valid_i[idx]) begin
                w_sel = idx[GW-1:0];
                found = 1'b1;
            end
        end
    end

    assign w_rx_hs  = (r_state == S_READ)  && m_rx_valid_i && s_rx_ready_i[r_gnt];
    assign w_tx_hs  = (r_state == S_WRITE) && s_tx_valid_i[r_gnt] && m_tx_ready_i;
    assign w_b_hs   = (r_state == S_WRITE) && m_b_valid_i && s_b_ready_i[r_gnt];
    assign w_err_hs = (r_state == S_ERR) &&
                      (w_is_wr ? s_b_ready_i[r_gnt] : s_rx_ready_i[r_gnt]);

    always_comb begin : p_next
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: if (m_trans_ready_i) w_state_nxt = w_is_wr ? S_WRITE : S_READ;
            S_READ: begin
                if (w_rx_hs && m_rx_i[17]) w_state_nxt = S_IDLE;
                else if (w_wd_fire)        w_state_nxt = S_ERR;
            end
            S_WRITE: begin
                if (w_b_hs && m_b_i[1]) w_state_nxt = S_IDLE;
                else if (w_wd_fire)     w_state_nxt = S_ERR;
            end
            S_ERR:   if (w_err_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Channel routing: everything towards a non-granted requester stays 0.
    always_comb begin : p_route
        s_trans_ready_o = '0;
        s_tx_ready_o    = '0;
        s_rx_valid_o    = '0;
        s_rx_o          = '0;
        s_b_valid_o     = '0;
        s_b_o           = '0;
        m_trans_valid_o = 1'b0;
        m_tx_valid_o    = 1'b0;
        m_tx_data_o     = '0;
        m_tx_strb_o     = '0;
        m_rx_ready_o    = 1'b0;
        m_b_ready_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) s_trans_ready_o[w_sel] = 1'b1;
            end
            S_ISSUE: begin
                m_trans_valid_o = 1'b1;
            end
            S_READ: begin
                s_rx_valid_o[r_gnt] = m_rx_valid_i;
                m_rx_ready_o        = s_rx_ready_i[r_gnt];
                s_rx_o              = m_rx_i;
            end
            S_WRITE: begin
                m_tx_valid_o        = s_tx_valid_i[r_gnt];
                m_tx_data_o         = s_tx_data_i[int'(r_gnt)*16 +: 16];
                m_tx_strb_o         = s_tx_strb_i[int'(r_gnt)*2 +: 2];
                s_tx_ready_o[r_gnt] = m_tx_ready_i;
                s_b_valid_o[r_gnt]  = m_b_valid_i;
                m_b_ready_o         = s_b_ready_i[r_gnt];
                s_b_o               = m_b_i;
            end
            S_ERR: begin
                // Synthesised terminating beat: {last=1, error=1}
                if (w_is_wr) begin
                    s_b_valid_o[r_gnt] = 1'b1;
                    s_b_o              = 2'b11;
                end else begin
                    s_rx_valid_o[r_gnt] = 1'b1;
                    s_rx_o              = {1'b1, 1'b1, 16'h0000};
                end
            end
            default: ;
        endcase
    end

    assign m_trans_o = r_trans;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_rr    <= '0;
            r_trans <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any) begin
                r_gnt   <= w_sel;
                r_trans <= s_trans_i[int'(w_sel)*TW +: TW];
            end
            // Pointer advances only once the master has taken the trans.
            if (r_state == S_ISSUE && m_trans_ready_i) begin
                r_rr <= (int'(r_gnt) == NR_REQ - 1) ? '0 : r_gnt + GW'(1);
            end
        end
    end

`ifdef HYPERBUS_ARB_WDOG_EN
    logic [31:0] r_cnt;
    logic        r_timeout;
    logic        w_active;
    logic        w_any_hs;

    assign w_active  = (r_state == S_READ) || (r_state == S_WRITE);
    assign w_any_hs  = w_rx_hs || w_tx_hs || w_b_hs;
    // A beat in the same cycle as the limit wins over the watchdog.
    assign w_wd_fire = w_active && (r_cnt >= 32'(TIMEOUT_CYC)) && !w_any_hs;
    assign timeout_o = r_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_any_hs || (w_state_nxt != r_state)) begin
                r_cnt <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_wd_fire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire
